// File: rtl/h264coeffunbuffer.sv
// Decoder coefficient reorder buffer: bitstream order in, transform order out, two-bank ping-pong.
// Optional per-block zero skip on the write side: define H264_UNBUF_ZEROSKIP_EN.
module h264coeffunbuffer #(
    parameter int DW      = 12,
    parameter int MBWORDS = 384
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          NEWSLICE,
    input  logic          VALIDI,
    input  logic [DW-1:0] ZIN,
`ifdef H264_UNBUF_ZEROSKIP_EN
    input  logic          ZSKIPI,
`endif
    output logic          READYI,
    input  logic          READYO,
    output logic [DW-1:0] VOUT,
    output logic          VALIDO,
    output logic          OCHF,
    output logic          ODC,
    output logic [3:0]    OSUB,
    output logic          DONE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [1:0] PH_L0 = 2'd0;
    localparam logic [1:0] PH_DC = 2'd1;
    localparam logic [1:0] PH_AC = 2'd2;
    localparam logic [1:0] PH_L1 = 2'd3;

    logic [DW-1:0] mem [2][MBWORDS];

    logic [1:0] full;
    logic       wb, rb;
    logic [8:0] wp;
    logic [1:0] state;
    logic [2:0] k;
    logic [1:0] ph;
    logic [3:0] w;
    logic       mb_end;

    logic       wr_en, wr_last, wr_data;
    logic [4:0] step;
    logic [9:0] wp_sum;
    logic [1:0] fset, fclr;
    logic       blk_last, pad, rd_zero;
    logic [8:0] ridx;

    assign wr_en = VALIDI && !full[wb];

`ifdef H264_UNBUF_ZEROSKIP_EN
    logic [23:0] zf [2];
    logic        l_first, c_first, skip, zblk;
    logic [2:0]  cidx;
    logic [4:0]  zidx, zsel;

    always_comb begin
        l_first = (wp < 9'd256) && (wp[3:0] == 4'd0);
        c_first = 1'b0;
        cidx    = '0;
        for (int c = 0; c < 8; c++) begin
            if (wp == 9'(264 + 15 * c)) begin
                c_first = 1'b1;
                cidx    = 3'(c);
            end
        end
        skip    = wr_en && ZSKIPI && (l_first || c_first);
        zidx    = l_first ? {1'b0, wp[7:4]} : 5'd16 + {2'b0, cidx};
        step    = !skip ? 5'd1 : (l_first ? 5'd16 : 5'd15);
        wr_data = wr_en && !skip;
    end

    // Zero flags follow the block's first write, so every block refreshes its flag each MB
    always_ff @(posedge CLK) begin
        if (wr_en && (l_first || c_first))
            zf[wb][zidx] <= skip;
    end

    always_comb begin
        zsel = (ph == PH_AC) ? 5'd16 + {2'b0, k} : {1'b0, k, ph[0]};
        zblk = (ph != PH_DC) && zf[rb][zsel];
    end
`else
    logic zblk;
    assign step    = 5'd1;
    assign wr_data = wr_en;
    assign zblk    = 1'b0;
`endif

    assign wp_sum  = {1'b0, wp} + {5'b0, step};
    assign wr_last = wp_sum == 10'(MBWORDS);

    always_ff @(posedge CLK) begin
        if (wr_data)
            mem[wb][wp] <= ZIN;
    end

    always_comb begin
        ridx = '0;
        unique case (ph)
            PH_L0: ridx = {1'b0, k, 1'b0, w};
            PH_L1: ridx = {1'b0, k, 1'b1, w};
            PH_DC: ridx = 9'd256 + {6'b0, k[2], 2'b0} + {7'b0, w[1:0]};
            PH_AC: ridx = 9'd264 + {2'b0, k, 4'b0} - {6'b0, k} + {5'b0, w};
        endcase
        pad = (ph == PH_AC) && (w == 4'd15);
        if (pad)
            ridx = '0;
        rd_zero  = pad || zblk;
        blk_last = (ph == PH_DC) ? (w == 4'd3) : (w == 4'd15);
    end

    always_comb begin
        fset = '0;
        fclr = '0;
        if (wr_en && wr_last)
            fset[wb] = 1'b1;
        if (state == S_GAP && mb_end)
            fclr[rb] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wp   <= '0;
            wb   <= 1'b0;
            full <= '0;
        end else if (NEWSLICE) begin
            wp   <= '0;
            wb   <= 1'b0;
            full <= '0;
        end else begin
            if (wr_en) begin
                wp <= wr_last ? 9'd0 : wp_sum[8:0];
                if (wr_last)
                    wb <= ~wb;
            end
            full <= (full | fset) & ~fclr;
        end
    end

    // Block walk: L(2k), optional DC group, C(k), L(2k+1); GAP between every block
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= S_IDLE;
            rb     <= 1'b0;
            k      <= '0;
            ph     <= PH_L0;
            w      <= '0;
            mb_end <= 1'b0;
        end else if (NEWSLICE) begin
            state  <= S_IDLE;
            rb     <= 1'b0;
            k      <= '0;
            ph     <= PH_L0;
            w      <= '0;
            mb_end <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    k      <= '0;
                    ph     <= PH_L0;
                    w      <= '0;
                    mb_end <= 1'b0;
                    if (full[rb] && READYO)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (blk_last) begin
                        state <= S_GAP;
                        w     <= '0;
                        unique case (ph)
                            PH_L0: ph <= (k == 3'd0 || k == 3'd4) ? PH_DC : PH_AC;
                            PH_DC: ph <= PH_AC;
                            PH_AC: ph <= PH_L1;
                            PH_L1: begin
                                ph <= PH_L0;
                                k  <= k + 3'd1;
                                if (k == 3'd7)
                                    mb_end <= 1'b1;
                            end
                        endcase
                    end else begin
                        w <= w + 4'd1;
                    end
                end
                S_GAP: begin
                    if (mb_end) begin
                        state  <= S_IDLE;
                        rb     <= ~rb;
                        mb_end <= 1'b0;
                    end else if (READYO) begin
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            VALIDO <= 1'b0;
            VOUT   <= '0;
            OCHF   <= 1'b0;
            ODC    <= 1'b0;
            OSUB   <= '0;
        end else if (NEWSLICE) begin
            VALIDO <= 1'b0;
            VOUT   <= '0;
            OCHF   <= 1'b0;
            ODC    <= 1'b0;
            OSUB   <= '0;
        end else if (state == S_RUN) begin
            VALIDO <= 1'b1;
            VOUT   <= rd_zero ? '0 : mem[rb][ridx];
            OCHF   <= (ph == PH_DC) || (ph == PH_AC);
            ODC    <= ph == PH_DC;
            unique case (ph)
                PH_L0:   OSUB <= {k, 1'b0};
                PH_L1:   OSUB <= {k, 1'b1};
                default: OSUB <= {1'b0, k};
            endcase
        end else begin
            VALIDO <= 1'b0;
            VOUT   <= '0;
            OCHF   <= 1'b0;
            ODC    <= 1'b0;
            OSUB   <= '0;
        end
    end

    assign READYI = !full[wb];
    assign DONE   = !full[0] && !full[1] && (state == S_IDLE) && (wp == 9'd0);

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RSTN && !NEWSLICE && VALIDI && full[wb])
            $error("h264coeffunbuffer: VALIDI while READYI low, word dropped");
    end
`endif

endmodule
